regfile_sequencer: RTL and testbench
====================================

# regfile_sequencer

Instruction sequencer for the 8-entry × 4-bit register file. It accepts one 16-bit instruction at a time over a valid/ready handshake. It drives the register file's two combinational read ports and its single write port, runs a 4-bit ALU operation, and writes the result back. It sits between the instruction source (test harness or future fetch unit) and the register file.

## Interface
- `DATA_W`, default 4: register width; fixed at 4 for this register file.
- `ADDR_W`, default 3: register address width (8 registers).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `instr`  in  16  instruction word: op[15:13], dst[12:10], src1[9:7], src2[6:4], imm[3:0].
- `instr_valid`  in  1  instruction present on `instr`.
- `instr_ready`  out  1  sequencer can accept an instruction; high only in IDLE.
- `rda1`  out  3  register file read address 1; driven from latched src1.
- `rda2`  out  3  register file read address 2; driven from latched src2.
- `rdd1`  in  4  register file read data 1, combinational from `rda1`.
- `rdd2`  in  4  register file read data 2, combinational from `rda2`.
- `wra`  out  3  register file write address.
- `wrd`  out  4  register file write data.
- `wr_en`  out  1  register file write enable.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `result`  out  4  value written, or 0 for NOP; valid while `done` is high.
- `carry`  out  1  ADD carry-out / SUB borrow; 0 for all other ops; valid with `done`.

## Operation
- Opcodes:
  - 000 NOP: no write.
  - 001 LDI: dst ← imm.
  - 010 MOV: dst ← rdd1.
  - 011 ADD: dst ← rdd1 + rdd2.
  - 100 SUB: dst ← rdd1 − rdd2.
  - 101 AND: dst ← rdd1 & rdd2.
  - 110 OR: dst ← rdd1 | rdd2.
  - 111 CLR: see Configuration.
- Arithmetic is 5-bit internally.
  - result = low 4 bits, wrapping mod 16.
  - ADD: carry = bit 4.
  - SUB: carry = 1 when rdd1 < rdd2 (borrow).
- State machine:
  - IDLE: `instr_ready`=1. When `instr_valid`, latch `instr` → EXEC. Otherwise stay.
  - EXEC: `rda1`/`rda2` driven from latched src1/src2. Operands are sampled from `rdd1`/`rdd2` and the ALU result is registered → WRITE. CLR (macro on) → CLEAR instead.
  - WRITE: `wra`=dst, `wrd`=result, `wr_en`=1 (0 for NOP). `done`=1 → IDLE.
  - CLEAR: 3-bit counter runs 0..7. `wra`=counter, `wrd`=0, `wr_en`=1 each cycle. At counter=7, `done`=1 → IDLE.
- src1, src2 and dst may be equal. Read happens in EXEC and the write commits at the end of WRITE, so there is no hazard within one instruction.
- The next instruction's EXEC reads the value written by the previous WRITE.
- `instr` is ignored whenever `instr_ready`=0. No internal buffering.

## Timing
- Reset asserted (low), at any time including mid-instruction:
  - state → IDLE, CLEAR counter → 0.
  - `wr_en`, `done`, `result`, `carry`, `wra`, `wrd`, `rda1`, `rda2` → 0.
  - `instr_ready` → 1 once reset deasserts.
  - An interrupted instruction is dropped; no partial write occurs after reset.
- Accept at edge N:
  - EXEC is cycle N+1.
  - WRITE is cycle N+2, with `done` high; the write commits at edge N+3.
  - `instr_ready` returns high in cycle N+3.
- Throughput is one instruction per 3 cycles.
- CLR: accept at N, EXEC at N+1, CLEAR at N+2..N+9, `done` in N+9, ready in N+10.
- `done`, `result` and `carry` are registered outputs.
- `wr_en` is high only in WRITE (non-NOP) or CLEAR.

## Configuration
- Macro `REGFILE_SEQ_CLEAR_EN`.
- Defined: CLEAR state and counter are compiled in. Op 111 zeroes all 8 registers over 8 write cycles.
- Undefined: CLEAR state and counter are absent. Op 111 decodes as NOP (3-cycle retire, no write, `result`=0).

## Structure
- Package `regfile_seq_pkg` holds:
  - opcode enum `op_e`
  - state enum `seq_state_e`
  - field position constants for the `instr` word
  - `DATA_W` and `ADDR_W` constants
- One sub-module `regfile_seq_alu`: purely combinational. Inputs op, a, b, imm. Outputs 4-bit result and carry.
- Top level holds the FSM, instruction latch, CLEAR counter and output registers.

## Test plan
- Reset low, then high; LDI r3,#9 → `wr_en`=1, `wra`=3, `wrd`=9 two cycles after accept; `done`=1, `result`=9.
- With r1=9, r2=8: ADD r4,r1,r2 → `result`=1, `carry`=1, r4=1. SUB r5,r2,r1 → `result`=0xF, `carry`=1.
- MOV r0,r3 followed back-to-back by AND r6,r0,r3 (r3=9) → r6=9. Confirms write-before-read ordering and that `instr_ready`=0 during EXEC and WRITE.
- Hold `instr_valid`=1 while busy with a changing `instr` → only the word present at the IDLE accept edge executes.
- Macro defined: CLR → 8 consecutive writes with `wra`=0..7, `wrd`=0, then one `done`. Macro undefined: CLR → no `wr_en`, `done` in the third cycle after accept.
- Drop `reset` low during WRITE and during CLEAR at counter=4 → `wr_en`=0 immediately. After release, state is IDLE and registers 4..7 are unchanged.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file instruction sequencer.
// Op 111 (CLR) is only a real clear when REGFILE_SEQ_CLEAR_EN is defined.
package regfile_seq_pkg;

   localparam int unsigned DataW  = 4;
   localparam int unsigned AddrW  = 3;
   localparam int unsigned InstrW = 16;

   // Instruction word field positions
   localparam int unsigned OpHi   = 15;
   localparam int unsigned OpLo   = 13;
   localparam int unsigned DstHi  = 12;
   localparam int unsigned DstLo  = 10;
   localparam int unsigned Src1Hi = 9;
   localparam int unsigned Src1Lo = 7;
   localparam int unsigned Src2Hi = 6;
   localparam int unsigned Src2Lo = 4;
   localparam int unsigned ImmHi  = 3;
   localparam int unsigned ImmLo  = 0;

   typedef enum logic [2:0] {
      OpNop = 3'b000,
      OpLdi = 3'b001,
      OpMov = 3'b010,
      OpAdd = 3'b011,
      OpSub = 3'b100,
      OpAnd = 3'b101,
      OpOr  = 3'b110,
      OpClr = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StWrite
`ifdef REGFILE_SEQ_CLEAR_EN
      , StClear
`endif
   } seq_state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational 4-bit ALU for the sequencer. ADD/SUB use a 5-bit datapath so
// bit 4 is the carry-out or the borrow; every other op reports carry 0.
module regfile_seq_alu
   import regfile_seq_pkg::*;
(
   input  op_e              op,
   input  logic [DataW-1:0] a,
   input  logic [DataW-1:0] b,
   input  logic [DataW-1:0] imm,
   output logic [DataW-1:0] result,
   output logic             carry
);

   logic [DataW:0] wide;

   always_comb begin
      wide   = '0;
      result = '0;
      carry  = 1'b0;
      case (op)
         OpLdi: result = imm;
         OpMov: result = a;
         OpAdd: begin
            wide   = {1'b0, a} + {1'b0, b};
            result = wide[DataW-1:0];
            carry  = wide[DataW];
         end
         OpSub: begin
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[DataW-1:0];
            carry  = wide[DataW];
         end
         OpAnd:   result = a & b;
         OpOr:    result = a | b;
         default: ; // NOP and CLR produce 0
      endcase
   end

endmodule

// File: rtl/regfile_sequencer.sv
// Instruction sequencer for the 8x4 register file: IDLE -> EXEC -> WRITE.
// With REGFILE_SEQ_CLEAR_EN defined, op 111 runs an 8-cycle CLEAR sweep.
module regfile_sequencer #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic [ADDR_W-1:0] rda1,
   output logic [ADDR_W-1:0] rda2,
   input  logic [DATA_W-1:0] rdd1,
   input  logic [DATA_W-1:0] rdd2,
   output logic [ADDR_W-1:0] wra,
   output logic [DATA_W-1:0] wrd,
   output logic              wr_en,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              carry
);
   import regfile_seq_pkg::*;

   seq_state_e        state_q, state_d;
   logic [InstrW-1:0] instr_q;
   op_e               op;
   logic [DataW-1:0]  alu_result;
   logic              alu_carry;
   logic              done_q;
   logic              carry_q;
   logic [DataW-1:0]  result_q;
`ifdef REGFILE_SEQ_CLEAR_EN
   logic [AddrW-1:0]  clr_cnt_q;
`endif

   assign op   = op_e'(instr_q[OpHi:OpLo]);
   assign rda1 = instr_q[Src1Hi:Src1Lo];
   assign rda2 = instr_q[Src2Hi:Src2Lo];

   assign done   = done_q;
   assign result = result_q;
   assign carry  = carry_q;

   regfile_seq_alu u_alu (
      .op     (op),
      .a      (rdd1),
      .b      (rdd2),
      .imm    (instr_q[ImmHi:ImmLo]),
      .result (alu_result),
      .carry  (alu_carry)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (instr_valid) state_d = StExec;
         StExec: begin
            state_d = StWrite;
`ifdef REGFILE_SEQ_CLEAR_EN
            if (op == OpClr) state_d = StClear;
`endif
         end
         StWrite: state_d = StIdle;
`ifdef REGFILE_SEQ_CLEAR_EN
         StClear: if (clr_cnt_q == 3'd7) state_d = StIdle;
`endif
         default: state_d = StIdle;
      endcase
   end

   // instr_ready is held low while reset is asserted
   always_comb begin
      instr_ready = reset && (state_q == StIdle);
      wra         = '0;
      wrd         = '0;
      wr_en       = 1'b0;
      unique case (state_q)
         StWrite: begin
            wra   = instr_q[DstHi:DstLo];
            wrd   = result_q;
            wr_en = (op != OpNop) && (op != OpClr);
         end
`ifdef REGFILE_SEQ_CLEAR_EN
         StClear: begin
            wra   = clr_cnt_q;
            wr_en = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_q  <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == StIdle && instr_valid) instr_q <= instr;
         // ALU reports 0/0 for CLR, so the clear sweep retires with result 0
         if (state_q == StExec) begin
            result_q <= alu_result;
            carry_q  <= alu_carry;
            done_q   <= (state_d == StWrite);
         end
`ifdef REGFILE_SEQ_CLEAR_EN
         if (state_q == StClear && clr_cnt_q == 3'd6) done_q <= 1'b1;
`endif
      end
   end

`ifdef REGFILE_SEQ_CLEAR_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clr_cnt_q <= '0;
      end else if (state_q == StClear) begin
         clr_cnt_q <= clr_cnt_q + 3'd1;
      end
   end
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 8x4 register file.
// CLR expectations follow REGFILE_SEQ_CLEAR_EN.
module tb_regfile_sequencer;

   localparam logic [2:0] NOP = 3'd0, LDI = 3'd1, MOV = 3'd2, ADD = 3'd3;
   localparam logic [2:0] SUB = 3'd4, AND = 3'd5, OR  = 3'd6, CLR = 3'd7;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [2:0]  rda1, rda2, wra;
   logic [3:0]  rdd1, rdd2, wrd, result;
   logic        wr_en, done, carry;

   logic [3:0]  rf [8];
   int          n_checks = 0;
   int          n_pass = 0;

   // Observations captured by run_instr
   logic        o_rdy_x, o_we_x, o_dn_x, o_rdy_w, o_we, o_dn, o_cy, o_rdy_i;
   logic [2:0]  o_wra;
   logic [3:0]  o_wrd, o_res;

   always #5 clk = ~clk;

   always @(posedge clk) if (wr_en) rf[wra] <= wrd;
   assign rdd1 = rf[rda1];
   assign rdd2 = rf[rda2];

   regfile_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .rda1        (rda1),
      .rda2        (rda2),
      .rdd1        (rdd1),
      .rdd2        (rdd2),
      .wra         (wra),
      .wrd         (wrd),
      .wr_en       (wr_en),
      .done        (done),
      .result      (result),
      .carry       (carry)
   );

   function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] d,
                                       input logic [2:0] s1, input logic [2:0] s2,
                                       input logic [3:0] imm);
      return {op, d, s1, s2, imm};
   endfunction

   // Starts at a negedge in IDLE, ends at the negedge of the following IDLE cycle
   task automatic run_instr(input logic [15:0] w);
      instr = w;
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      o_rdy_x = instr_ready; o_we_x = wr_en; o_dn_x = done;
      @(negedge clk);
      o_rdy_w = instr_ready; o_we = wr_en; o_wra = wra; o_wrd = wrd;
      o_dn = done; o_res = result; o_cy = carry;
      @(negedge clk);
      o_rdy_i = instr_ready;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++; if ({wr_en, done, carry} !== 3'b000)
         $display("FAIL rst_ctl got=%b want=000", {wr_en, done, carry}); else n_pass++;
      n_checks++; if ({result, wrd, wra, rda1, rda2} !== 17'd0)
         $display("FAIL rst_data got=%h want=0", {result, wrd, wra, rda1, rda2}); else n_pass++;
      reset = 1'b1;
      #1;
      n_checks++; if (instr_ready !== 1'b1)
         $display("FAIL rst_ready got=%b want=1", instr_ready); else n_pass++;
   endtask

   task automatic test_ldi();
      run_instr(enc(LDI, 3'd3, 3'd0, 3'd0, 4'd9));
      n_checks++; if ({o_rdy_x, o_we_x, o_dn_x} !== 3'b000)
         $display("FAIL ldi_exec got=%b want=000", {o_rdy_x, o_we_x, o_dn_x}); else n_pass++;
      n_checks++; if ({o_we, o_wra, o_wrd} !== {1'b1, 3'd3, 4'd9})
         $display("FAIL ldi_write got=%b/%0d/%0d want=1/3/9", o_we, o_wra, o_wrd); else n_pass++;
      n_checks++; if ({o_dn, o_res} !== {1'b1, 4'd9})
         $display("FAIL ldi_done got=%b/%0d want=1/9", o_dn, o_res); else n_pass++;
      n_checks++; if ({o_rdy_i, done, rf[3]} !== {1'b1, 1'b0, 4'd9})
         $display("FAIL ldi_retire got=%b/%b/%0d want=1/0/9", o_rdy_i, done, rf[3]);
      else n_pass++;
   endtask

   task automatic test_arith();
      run_instr(enc(LDI, 3'd1, 3'd0, 3'd0, 4'd9));
      run_instr(enc(LDI, 3'd2, 3'd0, 3'd0, 4'd8));
      run_instr(enc(ADD, 3'd4, 3'd1, 3'd2, 4'd0));
      n_checks++; if ({o_res, o_cy, o_wrd} !== {4'd1, 1'b1, 4'd1})
         $display("FAIL add got=%h/%b/%h want=1/1/1", o_res, o_cy, o_wrd); else n_pass++;
      n_checks++; if (rf[4] !== 4'd1) $display("FAIL add_r4 got=%h want=1", rf[4]); else n_pass++;
      run_instr(enc(SUB, 3'd5, 3'd2, 3'd1, 4'd0));
      n_checks++; if ({o_res, o_cy, rf[5]} !== {4'hF, 1'b1, 4'hF})
         $display("FAIL sub got=%h/%b/%h want=f/1/f", o_res, o_cy, rf[5]); else n_pass++;
      run_instr(enc(SUB, 3'd5, 3'd1, 3'd2, 4'd0));
      n_checks++; if ({o_res, o_cy} !== {4'd1, 1'b0})
         $display("FAIL sub_nb got=%h/%b want=1/0", o_res, o_cy); else n_pass++;
      run_instr(enc(OR, 3'd7, 3'd4, 3'd2, 4'd0));
      n_checks++; if ({o_res, o_cy, rf[7]} !== {4'd9, 1'b0, 4'd9})
         $display("FAIL or got=%h/%b/%h want=9/0/9", o_res, o_cy, rf[7]); else n_pass++;
      run_instr(enc(NOP, 3'd2, 3'd1, 3'd1, 4'd5));
      n_checks++; if ({o_we, o_dn, o_res, rf[2]} !== {1'b0, 1'b1, 4'd0, 4'd8})
         $display("FAIL nop got=%b/%b/%h/%h want=0/1/0/8", o_we, o_dn, o_res, rf[2]);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      run_instr(enc(MOV, 3'd0, 3'd3, 3'd0, 4'd0));
      n_checks++; if ({o_rdy_x, o_rdy_w, o_wra, o_wrd} !== {1'b0, 1'b0, 3'd0, 4'd9})
         $display("FAIL mov got=%b%b/%0d/%h want=00/0/9", o_rdy_x, o_rdy_w, o_wra, o_wrd);
      else n_pass++;
      run_instr(enc(AND, 3'd6, 3'd0, 3'd3, 4'd0));
      n_checks++; if ({o_rdy_x, o_rdy_w, o_res, rf[6]} !== {1'b0, 1'b0, 4'd9, 4'd9})
         $display("FAIL b2b_and got=%b%b/%h/%h want=00/9/9", o_rdy_x, o_rdy_w, o_res, rf[6]);
      else n_pass++;
   endtask

   task automatic test_hold_valid();
      instr = enc(LDI, 3'd7, 3'd0, 3'd0, 4'd5);
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr = enc(LDI, 3'd2, 3'd0, 3'd0, 4'hA);
      @(negedge clk);
      n_checks++; if ({wr_en, wra, wrd} !== {1'b1, 3'd7, 4'd5})
         $display("FAIL hold_write got=%b/%0d/%h want=1/7/5", wr_en, wra, wrd); else n_pass++;
      instr_valid = 1'b0;
      @(negedge clk);
      n_checks++; if ({rf[7], rf[2], instr_ready} !== {4'd5, 4'd8, 1'b1})
         $display("FAIL hold_rf got=%h/%h/%b want=5/8/1", rf[7], rf[2], instr_ready);
      else n_pass++;
   endtask

   task automatic test_clr();
`ifdef REGFILE_SEQ_CLEAR_EN
      instr = enc(CLR, 3'd0, 3'd0, 3'd0, 4'd0);
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      n_checks++; if ({wr_en, instr_ready} !== 2'b00)
         $display("FAIL clr_exec got=%b want=00", {wr_en, instr_ready}); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_checks++;
         if ({wr_en, wra, wrd, done} !== {1'b1, 3'(i), 4'd0, (i == 7)})
            $display("FAIL clr_step%0d got=%b/%0d/%h/%b want=1/%0d/0/%b",
                     i, wr_en, wra, wrd, done, i, (i == 7));
         else n_pass++;
      end
      @(negedge clk);
      n_checks++; if ({instr_ready, done, wr_en} !== 3'b100)
         $display("FAIL clr_end got=%b want=100", {instr_ready, done, wr_en}); else n_pass++;
      n_checks++; if ({rf[0], rf[3], rf[5], rf[7]} !== 16'd0)
         $display("FAIL clr_rf got=%h want=0", {rf[0], rf[3], rf[5], rf[7]}); else n_pass++;
`else
      run_instr(enc(CLR, 3'd0, 3'd0, 3'd0, 4'd0));
      n_checks++; if ({o_we_x, o_we, o_dn_x, o_dn, o_res} !== {4'b0001, 4'd0})
         $display("FAIL clr_nop got=%b%b%b%b/%h want=0001/0", o_we_x, o_we, o_dn_x, o_dn,
                  o_res);
      else n_pass++;
      n_checks++; if ({o_rdy_i, rf[7], rf[3]} !== {1'b1, 4'd5, 4'd9})
         $display("FAIL clr_rf got=%b/%h/%h want=1/5/9", o_rdy_i, rf[7], rf[3]); else n_pass++;
`endif
   endtask

   task automatic test_reset_mid();
      run_instr(enc(LDI, 3'd4, 3'd0, 3'd0, 4'hC));
      run_instr(enc(LDI, 3'd5, 3'd0, 3'd0, 4'hD));
      run_instr(enc(LDI, 3'd6, 3'd0, 3'd0, 4'hE));
      run_instr(enc(LDI, 3'd7, 3'd0, 3'd0, 4'h7));
      instr = enc(LDI, 3'd4, 3'd0, 3'd0, 4'h1);
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++; if ({wr_en, done, result} !== 6'd0)
         $display("FAIL rstw got=%b/%b/%h want=0/0/0", wr_en, done, result); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++; if ({instr_ready, rf[4]} !== {1'b1, 4'hC})
         $display("FAIL rstw_rf got=%b/%h want=1/c", instr_ready, rf[4]); else n_pass++;
      @(negedge clk);
`ifdef REGFILE_SEQ_CLEAR_EN
      instr = enc(CLR, 3'd0, 3'd0, 3'd0, 4'd0);
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++; if ({wr_en, wra} !== {1'b1, 3'd4})
         $display("FAIL rstc_cnt got=%b/%0d want=1/4", wr_en, wra); else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++; if ({wr_en, wra, done} !== 5'd0)
         $display("FAIL rstc got=%b/%0d/%b want=0/0/0", wr_en, wra, done); else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++; if ({instr_ready, rf[4], rf[5], rf[6], rf[7]} !== {1'b1, 16'hCDE7})
         $display("FAIL rstc_rf got=%b/%h%h%h%h want=1/cde7", instr_ready, rf[4], rf[5],
                  rf[6], rf[7]);
      else n_pass++;
      @(negedge clk);
`endif
      run_instr(enc(LDI, 3'd2, 3'd0, 3'd0, 4'd6));
      n_checks++; if ({o_we, o_wra, o_wrd, o_dn} !== {1'b1, 3'd2, 4'd6, 1'b1})
         $display("FAIL post_rst got=%b/%0d/%h/%b want=1/2/6/1", o_we, o_wra, o_wrd, o_dn);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rf[i] = '0;
      test_reset();
      @(negedge clk);
      test_ldi();
      test_arith();
      test_back_to_back();
      test_hold_valid();
      test_clr();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
